// File: rtl/exp_sel_pkg.sv
// Shared expansion-port types for the config/hub slice.
// Holds the expansion selection encoding, the switch sequencer state type and
// the helper that folds a raw config type field into a legal selection.
package exp_sel_pkg;

    typedef logic [1:0] exp_sel_t;

    localparam exp_sel_t EXP_OFF = 2'd0;
    localparam exp_sel_t EXP_CDR = 2'd1;
    localparam exp_sel_t EXP_TNB = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GUARD = 2'd2,
        ST_RESET = 2'd3
    } seq_state_t;

    // Unknown type codes park the port at OFF rather than selecting garbage.
    function automatic exp_sel_t norm_exp_type(input logic [7:0] raw_type);
        exp_sel_t sel;
        sel = (raw_type <= 8'd2) ? raw_type[1:0] : EXP_OFF;
        return sel;
    endfunction

endpackage

// File: rtl/exp_sel_seq.sv
// Expansion-port switch sequencer.
// Follows the requested expansion type from system config and, on a change,
// drains the bus, isolates the port (OFF) for a guard period, then commits the
// new selection while holding the incoming device in reset. The hub mux
// selects on exp_sel instead of the raw config field.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   req_type  requested expansion type (0=OFF, 1=CDR, 2=TNB, other=OFF)
//   bus_busy  expansion bus cycle in progress
//   exp_sel   committed selection for the hub mux (registered)
//   dev_rst   reset to expansion devices, active-high (registered)
//   sw_busy   switch sequence in progress (registered)
//   drain_tmo sticky: last drain gave up waiting for the bus (registered)
module exp_sel_seq
    import exp_sel_pkg::*;
#(
    parameter int DRAIN_TMO = 255,
    parameter int GUARD_CYC = 16,
    parameter int RST_CYC   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_type,
    input  logic       bus_busy,
    output logic [1:0] exp_sel,
    output logic       dev_rst,
    output logic       sw_busy,
    output logic       drain_tmo
);

    localparam int W_DRAIN = $clog2(DRAIN_TMO + 1);
    localparam int W_GUARD = $clog2(GUARD_CYC + 1);
    localparam int W_RST   = $clog2(RST_CYC + 1);
    localparam int W_A     = (W_DRAIN > W_GUARD) ? W_DRAIN : W_GUARD;
    localparam int W_B     = (W_A > W_RST) ? W_A : W_RST;
    localparam int CNT_W   = (W_B > 8) ? W_B : 8;

    // The counter holds "cycles already spent in this state"; a state of
    // length L is left when it reads L-1.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TMO - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    seq_state_t       state;
    exp_sel_t         cur;
    exp_sel_t         tgt;
    exp_sel_t         req_n;
    logic [CNT_W-1:0] cnt;

    assign req_n = norm_exp_type(req_type);

    // Outputs are assigned together with each transition so they always
    // reflect the state being entered, with no decode after the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RESET;
            cur       <= EXP_OFF;
            tgt       <= EXP_OFF;
            cnt       <= '0;
            exp_sel   <= EXP_OFF;
            dev_rst   <= 1'b1;
            sw_busy   <= 1'b1;
            drain_tmo <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (req_n != cur) begin
                        tgt       <= req_n;
                        drain_tmo <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_DRAIN;
                        sw_busy   <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (req_n == cur) begin
                        // Request withdrawn before the port was touched:
                        // exp_sel never left cur, so just resume.
                        state   <= ST_RUN;
                        sw_busy <= 1'b0;
                    end else begin
                        tgt <= req_n;
                        if (!bus_busy || cnt == DRAIN_LAST) begin
                            if (bus_busy) begin
                                drain_tmo <= 1'b1;
                            end
                            state   <= ST_GUARD;
                            cnt     <= '0;
                            exp_sel <= EXP_OFF;
                            dev_rst <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_GUARD: begin
                    if (req_n != tgt) begin
                        // New destination: restart the full isolation period.
                        tgt <= req_n;
                        cnt <= '0;
                    end else if (cnt == GUARD_LAST) begin
                        cur     <= tgt;
                        state   <= ST_RESET;
                        cnt     <= '0;
                        exp_sel <= tgt;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESET: begin
                    if (req_n != tgt) begin
                        tgt     <= req_n;
                        state   <= ST_GUARD;
                        cnt     <= '0;
                        exp_sel <= EXP_OFF;
                    end else if (cnt == RST_LAST) begin
                        state   <= ST_RUN;
                        dev_rst <= 1'b0;
                        sw_busy <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_RESET;
                    cnt     <= '0;
                    exp_sel <= cur;
                    dev_rst <= 1'b1;
                    sw_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule
